// File: rtl/sram_arbiter_pkg.sv
// ============================================================================
// Module      : sram_arbiter_pkg
// Description : Shared FSM state encoding and requester ids for the SRAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic REQ_IFU = 1'b0;
    localparam logic REQ_LSU = 1'b1;

endpackage

`default_nettype wire

// File: rtl/sram_arbiter_if.sv
// ============================================================================
// Module      : sram_arbiter_if
// Description : Requester handshakes (IFU, LSU) and BaseRAM pins of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sram_arbiter_if;
    logic        ifu_req_i;
    logic [31:0] ifu_addr_i;
    logic [31:0] ifu_wdata_i;
    logic [3:0]  ifu_be_n_i;
    logic        ifu_re_n_i;
    logic        ifu_we_n_i;
    logic        ifu_resp_o;
    logic [31:0] ifu_rdata_o;

    logic        lsu_req_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic [3:0]  lsu_be_n_i;
    logic        lsu_re_n_i;
    logic        lsu_we_n_i;
    logic        lsu_resp_o;
    logic [31:0] lsu_rdata_o;

    logic [19:0] sram_addr_o;
    logic [31:0] sram_wdata_o;
    logic [31:0] sram_rdata_i;
    logic [3:0]  sram_be_n_o;
    logic        sram_ce_n_o;
    logic        sram_oe_n_o;
    logic        sram_we_n_o;
    logic        busy_o;

    modport slave (
        input  ifu_req_i, ifu_addr_i, ifu_wdata_i, ifu_be_n_i, ifu_re_n_i, ifu_we_n_i,
        output ifu_resp_o, ifu_rdata_o,
        input  lsu_req_i, lsu_addr_i, lsu_wdata_i, lsu_be_n_i, lsu_re_n_i, lsu_we_n_i,
        output lsu_resp_o, lsu_rdata_o,
        output sram_addr_o, sram_wdata_o, sram_be_n_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o,
        input  sram_rdata_i,
        output busy_o
    );

    modport master (
        output ifu_req_i, ifu_addr_i, ifu_wdata_i, ifu_be_n_i, ifu_re_n_i, ifu_we_n_i,
        input  ifu_resp_o, ifu_rdata_o,
        output lsu_req_i, lsu_addr_i, lsu_wdata_i, lsu_be_n_i, lsu_re_n_i, lsu_we_n_i,
        input  lsu_resp_o, lsu_rdata_o,
        input  sram_addr_o, sram_wdata_o, sram_be_n_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o,
        output sram_rdata_i,
        input  busy_o
    );
endinterface

`default_nettype wire

// File: rtl/sram_arb_pick.sv
// ============================================================================
// Module      : sram_arb_pick
// Description : Combinational two-requester picker. Default: LSU priority with
//               forced IFU grant when starved. SRAM_ARB_RR_EN: round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_arb_pick
    import sram_arbiter_pkg::*;
(
    input  logic ifu_req_i,
    input  logic lsu_req_i,
`ifdef SRAM_ARB_RR_EN
    input  logic last_grant_i,
`else
    input  logic starved_i,
`endif
    output logic grant_o
);

    always_comb begin
        grant_o = REQ_LSU;
        if (ifu_req_i && !lsu_req_i) begin
            grant_o = REQ_IFU;
        end else if (ifu_req_i && lsu_req_i) begin
`ifdef SRAM_ARB_RR_EN
            grant_o = (last_grant_i == REQ_LSU) ? REQ_IFU : REQ_LSU;
`else
            grant_o = starved_i ? REQ_IFU : REQ_LSU;
`endif
        end
    end

endmodule

`default_nettype wire

// File: rtl/sram_arbiter.sv
// ============================================================================
// Module      : sram_arbiter
// Description : Shares one asynchronous SRAM between IFU and LSU with registered
//               multi-cycle pin timing. Option macro: SRAM_ARB_RR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES  = 3,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    sram_arbiter_if.slave bus
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        grant_q, grant_d;
    logic [19:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_n_q, be_n_d;
    logic        lat_we_n_q, lat_we_n_d;
    logic        ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic        ifu_resp_q, ifu_resp_d;
    logic        lsu_resp_q, lsu_resp_d;
    logic [31:0] ifu_rdata_q, ifu_rdata_d;
    logic [31:0] lsu_rdata_q, lsu_rdata_d;

    logic        w_pick;
    logic        w_op_re_n;
    logic        w_op_we_n;
    logic        w_unused;

    assign w_unused = &{1'b0, bus.ifu_addr_i[31:22], bus.ifu_addr_i[1:0],
                        bus.lsu_addr_i[31:22], bus.lsu_addr_i[1:0]};

`ifdef SRAM_ARB_RR_EN
    // Nothing has been granted after reset, so LSU leads the first contention.
    logic rr_last_q, rr_last_d;

    sram_arb_pick u_pick (
        .ifu_req_i    (bus.ifu_req_i),
        .lsu_req_i    (bus.lsu_req_i),
        .last_grant_i (rr_last_q),
        .grant_o      (w_pick)
    );
`else
    logic [SW-1:0] starve_q, starve_d;

    sram_arb_pick u_pick (
        .ifu_req_i (bus.ifu_req_i),
        .lsu_req_i (bus.lsu_req_i),
        .starved_i (starve_q == SW'(STARVE_LIMIT)),
        .grant_o   (w_pick)
    );
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_n_d      = be_n_q;
        lat_we_n_d  = lat_we_n_q;
        ce_n_d      = ce_n_q;
        oe_n_d      = oe_n_q;
        we_n_d      = we_n_q;
        ifu_resp_d  = 1'b0;
        lsu_resp_d  = 1'b0;
        ifu_rdata_d = ifu_rdata_q;
        lsu_rdata_d = lsu_rdata_q;
        w_op_re_n   = 1'b1;
        w_op_we_n   = 1'b1;
`ifdef SRAM_ARB_RR_EN
        rr_last_d   = rr_last_q;
`else
        starve_d    = starve_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.ifu_req_i || bus.lsu_req_i) begin
                    grant_d = w_pick;
                    if (w_pick == REQ_IFU) begin
                        addr_d    = bus.ifu_addr_i[21:2];
                        wdata_d   = bus.ifu_wdata_i;
                        be_n_d    = bus.ifu_be_n_i;
                        w_op_re_n = bus.ifu_re_n_i;
                        w_op_we_n = bus.ifu_we_n_i;
                    end else begin
                        addr_d    = bus.lsu_addr_i[21:2];
                        wdata_d   = bus.lsu_wdata_i;
                        be_n_d    = bus.lsu_be_n_i;
                        w_op_re_n = bus.lsu_re_n_i;
                        w_op_we_n = bus.lsu_we_n_i;
                    end
                    lat_we_n_d = w_op_we_n;
                    // A write never drives the output buffer, even if re_n is also low.
                    oe_n_d     = w_op_re_n | ~w_op_we_n;
                    ce_n_d     = 1'b0;
                    we_n_d     = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_ACCESS;
`ifdef SRAM_ARB_RR_EN
                    rr_last_d  = w_pick;
`else
                    if (w_pick == REQ_IFU) begin
                        starve_d = '0;
                    end else if (bus.ifu_req_i) begin
                        starve_d = starve_q + 1'b1;
                    end
`endif
                end
            end

            ST_ACCESS: begin
                if (cnt_q == CW'(WAIT_CYCLES - 1)) begin
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    state_d = ST_DONE;
                    if (grant_q == REQ_IFU) begin
                        ifu_resp_d  = 1'b1;
                        ifu_rdata_d = bus.sram_rdata_i;
                    end else begin
                        lsu_resp_d  = 1'b1;
                        lsu_rdata_d = bus.sram_rdata_i;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    // First and last access cycles keep we_n high for address setup/hold.
                    we_n_d = !(!lat_we_n_q && (int'(cnt_q) < WAIT_CYCLES - 2));
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            grant_q     <= REQ_LSU;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_n_q      <= 4'hF;
            lat_we_n_q  <= 1'b1;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            ifu_resp_q  <= 1'b0;
            lsu_resp_q  <= 1'b0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
`ifdef SRAM_ARB_RR_EN
            rr_last_q   <= REQ_IFU;
`else
            starve_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_n_q      <= be_n_d;
            lat_we_n_q  <= lat_we_n_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            ifu_resp_q  <= ifu_resp_d;
            lsu_resp_q  <= lsu_resp_d;
            ifu_rdata_q <= ifu_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
`ifdef SRAM_ARB_RR_EN
            rr_last_q   <= rr_last_d;
`else
            starve_q    <= starve_d;
`endif
        end
    end

    assign bus.sram_addr_o  = addr_q;
    assign bus.sram_wdata_o = wdata_q;
    assign bus.sram_be_n_o  = be_n_q;
    assign bus.sram_ce_n_o  = ce_n_q;
    assign bus.sram_oe_n_o  = oe_n_q;
    assign bus.sram_we_n_o  = we_n_q;
    assign bus.ifu_resp_o   = ifu_resp_q;
    assign bus.lsu_resp_o   = lsu_resp_q;
    assign bus.ifu_rdata_o  = ifu_rdata_q;
    assign bus.lsu_rdata_o  = lsu_rdata_q;
    assign bus.busy_o       = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// ============================================================================
// Module      : tb_sram_arbiter
// Description : Directed bench for sram_arbiter (WAIT_CYCLES=3, STARVE_LIMIT=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    sram_arbiter_if bus ();

    sram_arbiter #(
        .WAIT_CYCLES  (3),
        .STARVE_LIMIT (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic        is_lsu;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be_n;
        logic        re_n;
        logic        we_n;
        logic [31:0] rd_in;
        logic [19:0] exp_addr;
        logic        exp_oe_n;
        logic [2:0]  exp_we_mask;   // bit i set: we_n low in access cycle i+1
        logic        chk_rd;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] exp_rd[2];
    logic        rd_known[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic lsu, input logic req, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be_n,
                         input logic re_n, input logic we_n);
        if (lsu) begin
            bus.lsu_req_i = req;   bus.lsu_addr_i = addr; bus.lsu_wdata_i = wdata;
            bus.lsu_be_n_i = be_n; bus.lsu_re_n_i = re_n; bus.lsu_we_n_i = we_n;
        end else begin
            bus.ifu_req_i = req;   bus.ifu_addr_i = addr; bus.ifu_wdata_i = wdata;
            bus.ifu_be_n_i = be_n; bus.ifu_re_n_i = re_n; bus.ifu_we_n_i = we_n;
        end
    endtask

    task automatic check_resp(input string tag, input int k, input logic e_ifu, input logic e_lsu);
        check($sformatf("%s k%0d ifu_resp", tag, k), {31'b0, bus.ifu_resp_o}, {31'b0, e_ifu});
        check($sformatf("%s k%0d lsu_resp", tag, k), {31'b0, bus.lsu_resp_o}, {31'b0, e_lsu});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 32'h8000_0010, 32'h0000_0000, 4'h0, 1'b0, 1'b1, 32'h1234_5678, 20'h00004, 1'b0, 3'b000, 1'b1};
        vecs[1] = '{1'b1, 32'h8000_0100, 32'hCAFE_F00D, 4'hC, 1'b1, 1'b0, 32'hDEAD_BEEF, 20'h00040, 1'b1, 3'b010, 1'b0};
        vecs[2] = '{1'b1, 32'h803F_FFFC, 32'h5555_AAAA, 4'h0, 1'b0, 1'b0, 32'h0000_0000, 20'hFFFFF, 1'b1, 3'b010, 1'b0};
        vecs[3] = '{1'b1, 32'h8012_3454, 32'h0000_0001, 4'h0, 1'b0, 1'b1, 32'h0BAD_F00D, 20'h48D15, 1'b0, 3'b000, 1'b1};
        vecs[4] = '{1'b0, 32'h0000_0008, 32'h0000_0002, 4'hF, 1'b1, 1'b1, 32'h7777_7777, 20'h00002, 1'b1, 3'b000, 1'b0};
        vecs[5] = '{1'b0, 32'h0000_0FFC, 32'h0000_0003, 4'h0, 1'b0, 1'b1, 32'hA5A5_5A5A, 20'h003FF, 1'b0, 3'b000, 1'b1};
        rd_known[0] = 1'b0;
        rd_known[1] = 1'b0;

        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'hF, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 1'b1, 1'b1);
        bus.sram_rdata_i = 32'h0;

        // Reset values
        rst = 1'b1;
        tick();
        tick();
        check("rst ce_n", {31'b0, bus.sram_ce_n_o}, 32'd1);
        check("rst oe_n", {31'b0, bus.sram_oe_n_o}, 32'd1);
        check("rst we_n", {31'b0, bus.sram_we_n_o}, 32'd1);
        check("rst be_n", {28'b0, bus.sram_be_n_o}, 32'hF);
        check("rst addr", {12'b0, bus.sram_addr_o}, 32'h0);
        check("rst wdata", bus.sram_wdata_o, 32'h0);
        check("rst ifu_rdata", bus.ifu_rdata_o, 32'h0);
        check("rst lsu_rdata", bus.lsu_rdata_o, 32'h0);
        check_resp("rst", 0, 1'b0, 1'b0);
        check("rst busy", {31'b0, bus.busy_o}, 32'd0);
        rst = 1'b0;
        tick();

        // Single-requester transactions
        for (int v = 0; v < 6; v++) begin
            int p;
            int o;
            p = vecs[v].is_lsu ? 1 : 0;
            o = 1 - p;
            drive(vecs[v].is_lsu, 1'b1, vecs[v].addr, vecs[v].wdata, vecs[v].be_n,
                  vecs[v].re_n, vecs[v].we_n);
            bus.sram_rdata_i = vecs[v].rd_in;
            tick();
            for (int c = 1; c <= 3; c++) begin
                check($sformatf("v%0d c%0d ce_n", v, c), {31'b0, bus.sram_ce_n_o}, 32'd0);
                check($sformatf("v%0d c%0d oe_n", v, c), {31'b0, bus.sram_oe_n_o}, {31'b0, vecs[v].exp_oe_n});
                check($sformatf("v%0d c%0d we_n", v, c), {31'b0, bus.sram_we_n_o}, {31'b0, ~vecs[v].exp_we_mask[c-1]});
                check($sformatf("v%0d c%0d addr", v, c), {12'b0, bus.sram_addr_o}, {12'b0, vecs[v].exp_addr});
                check($sformatf("v%0d c%0d be_n", v, c), {28'b0, bus.sram_be_n_o}, {28'b0, vecs[v].be_n});
                check($sformatf("v%0d c%0d wdata", v, c), bus.sram_wdata_o, vecs[v].wdata);
                check($sformatf("v%0d c%0d busy", v, c), {31'b0, bus.busy_o}, 32'd1);
                if (c < 3) tick();
            end
            tick();
            check_resp($sformatf("v%0d", v), 4, vecs[v].is_lsu == 1'b0, vecs[v].is_lsu == 1'b1);
            check($sformatf("v%0d done ce_n", v), {31'b0, bus.sram_ce_n_o}, 32'd1);
            if (vecs[v].chk_rd) begin
                check($sformatf("v%0d rdata", v), p ? bus.lsu_rdata_o : bus.ifu_rdata_o, vecs[v].rd_in);
                exp_rd[p] = vecs[v].rd_in;
            end
            rd_known[p] = vecs[v].chk_rd;
            if (rd_known[o])
                check($sformatf("v%0d other rdata held", v), o ? bus.lsu_rdata_o : bus.ifu_rdata_o, exp_rd[o]);
            drive(vecs[v].is_lsu, 1'b0, vecs[v].addr, vecs[v].wdata, vecs[v].be_n,
                  vecs[v].re_n, vecs[v].we_n);
            tick();
            check($sformatf("v%0d idle busy", v), {31'b0, bus.busy_o}, 32'd0);
            check_resp($sformatf("v%0d", v), 5, 1'b0, 1'b0);
        end

        // Contention: LSU first, IFU served in the following slot
        drive(1'b0, 1'b1, 32'h8000_0020, 32'h0, 4'h0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 32'h8000_0030, 32'h0, 4'h0, 1'b0, 1'b1);
        bus.sram_rdata_i = 32'h1111_1111;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check_resp("A", k, k == 9, k == 4);
            if (k == 2) check("A lsu addr", {12'b0, bus.sram_addr_o}, 32'h0000C);
            if (k == 7) check("A ifu addr", {12'b0, bus.sram_addr_o}, 32'h00008);
            if (k == 4) begin
                check("A lsu rdata", bus.lsu_rdata_o, 32'h1111_1111);
                bus.lsu_req_i = 1'b0;
                bus.sram_rdata_i = 32'h2222_2222;
            end
            if (k == 9) begin
                check("A ifu rdata", bus.ifu_rdata_o, 32'h2222_2222);
                bus.ifu_req_i = 1'b0;
            end
        end
        tick();
        check("A idle busy", {31'b0, bus.busy_o}, 32'd0);

`ifndef SRAM_ARB_RR_EN
        // Starvation: LSU back-to-back, IFU forced on the third arbitration
        drive(1'b0, 1'b1, 32'h8000_0040, 32'h0, 4'h0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 32'h8000_0050, 32'h0, 4'h0, 1'b0, 1'b1);
        for (int k = 1; k <= 19; k++) begin
            tick();
            check_resp("B", k, k == 14, (k == 4) || (k == 9) || (k == 19));
            if (k == 12) check("B ifu addr", {12'b0, bus.sram_addr_o}, 32'h00010);
            if (k == 17) check("B lsu addr", {12'b0, bus.sram_addr_o}, 32'h00014);
            if (k == 14) bus.ifu_req_i = 1'b0;
            if (k == 19) bus.lsu_req_i = 1'b0;
        end
        tick();
`else
        // Round-robin: grants alternate while both requesters stay high
        drive(1'b0, 1'b1, 32'h8000_0060, 32'h0, 4'h0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 32'h8000_0070, 32'h0, 4'h0, 1'b0, 1'b1);
        for (int k = 1; k <= 19; k++) begin
            tick();
            check_resp("RR", k, (k == 9) || (k == 19), (k == 4) || (k == 14));
            if (k == 7) check("RR ifu addr", {12'b0, bus.sram_addr_o}, 32'h00018);
            if (k == 19) begin
                bus.ifu_req_i = 1'b0;
                bus.lsu_req_i = 1'b0;
            end
        end
        tick();
`endif

        // Request dropped after one cycle still completes
        drive(1'b0, 1'b1, 32'h8000_0044, 32'h0F0F_0F0F, 4'h0, 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) bus.ifu_req_i = 1'b0;
            check_resp("C", k, k == 4, 1'b0);
            if (k <= 3) check($sformatf("C k%0d we_n", k), {31'b0, bus.sram_we_n_o}, {31'b0, k != 2});
        end
        check("C idle busy", {31'b0, bus.busy_o}, 32'd0);

        // Reset during the second access cycle aborts the transaction
        drive(1'b1, 1'b1, 32'h8000_0080, 32'h0, 4'h0, 1'b0, 1'b1);
        bus.sram_rdata_i = 32'h3333_3333;
        tick();
        tick();
        check("D access ce_n", {31'b0, bus.sram_ce_n_o}, 32'd0);
        rst = 1'b1;
        bus.lsu_req_i = 1'b0;
        tick();
        check("D ce_n", {31'b0, bus.sram_ce_n_o}, 32'd1);
        check("D oe_n", {31'b0, bus.sram_oe_n_o}, 32'd1);
        check("D busy", {31'b0, bus.busy_o}, 32'd0);
        check("D lsu_rdata", bus.lsu_rdata_o, 32'h0);
        check_resp("D", 3, 1'b0, 1'b0);
        rst = 1'b0;
        for (int k = 4; k <= 7; k++) begin
            tick();
            check_resp("D", k, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Sequential arbiter and timing controller that shares one asynchronous SRAM port (BaseRAM) between the instruction-fetch and load/store requesters. It accepts one transaction at a time over a req/resp handshake and generates multi-cycle SRAM control timing from registered outputs. It returns registered read data to each requester. It sits between IFU/LSU and the board SRAM pins; address decode to BaseRAM is done upstream.

Parameters:
WAIT_CYCLES, 3, SRAM access cycles per transaction (ce_n low); legal range >= 3.
STARVE_LIMIT, 4, consecutive LSU wins over a waiting IFU before IFU is forced; legal range >= 1.

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
ifu_req_i  in  1  IFU request; held with operands until resp
ifu_addr_i  in  32  byte address; bits [21:2] used
ifu_wdata_i  in  32  write data
ifu_be_n_i  in  4  byte enables, active-low
ifu_re_n_i  in  1  read enable, active-low
ifu_we_n_i  in  1  write enable, active-low
ifu_resp_o  out  1  one-cycle completion pulse
ifu_rdata_o  out  32  read data; valid with resp, held until the next IFU resp
lsu_*  (same eight ports, same widths and meanings, lsu_ prefix)
sram_addr_o  out  20  word address
sram_wdata_o  out  32  write data
sram_rdata_i  in  32  read data
sram_be_n_o  out  4  byte enables, active-low
sram_ce_n_o  out  1  chip enable, active-low
sram_oe_n_o  out  1  output enable, active-low
sram_we_n_o  out  1  write enable, active-low
busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset values: state IDLE; ce_n/oe_n/we_n = 1; be_n = 4'hF; addr, wdata, both rdata = 0; both resp = 0; starve_cnt = 0; grant = LSU.
- All SRAM outputs come from flops; there is no combinational path from req to the pins.
- FSM IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - If any req is high, pick the winner and latch its addr[21:2], wdata, be_n, re_n, we_n.
  - Set cnt = 0 and go to ACCESS.
  - Otherwise stay in IDLE.
- Arbitration (default):
  - LSU has fixed priority.
  - When both requesters are high and LSU wins, starve_cnt increments.
  - When starve_cnt == STARVE_LIMIT and both are high, IFU wins.
  - starve_cnt clears on any IFU grant.
- ACCESS lasts WAIT_CYCLES cycles; cnt runs 0..WAIT_CYCLES-1.
  - ce_n = 0.
  - oe_n = latched re_n.
  - we_n = 0 only for cnt in 1..WAIT_CYCLES-2 when latched we_n = 0, which gives address setup and hold around the write pulse.
  - At cnt == WAIT_CYCLES-1, sram_rdata_i is captured; then go to DONE.
- DONE:
  - ce_n/oe_n/we_n return to 1.
  - The granted requester gets resp = 1 for exactly one cycle, with its rdata updated to the captured word (writes update it too; the value is don't-care).
  - Go to IDLE.
- Latency: req seen in IDLE at cycle T gives ACCESS at T+1..T+WAIT_CYCLES and resp at T+WAIT_CYCLES+1. Throughput is one transaction per WAIT_CYCLES+2 cycles.
- Handshake: at the edge that samples resp = 1, the requester either drops req or presents a new transaction with req still high. Operands must stay stable while req is high and no resp has been received.
- Edge cases:
  - re_n = we_n = 0: write wins, oe_n forced to 1.
  - re_n = we_n = 1: no-op transaction, still full timing and resp.
  - req dropped mid-transaction: ignored; the transaction completes and resp is still issued.
  - rst during ACCESS or DONE: transaction aborted; pins inactive at the next edge; no resp issued.

Optional Feature:
SRAM_ARB_RR_EN
- Defined: round-robin arbitration. The last-granted requester has lowest priority on contention, starve_cnt is removed, and STARVE_LIMIT is unused.
- Undefined: LSU priority with the starvation limit described above.

Decomposition:
- Shared package: FSM state enum (IDLE/ACCESS/DONE) and requester-id constants (REQ_IFU = 0, REQ_LSU = 1).
- One natural sub-module, sram_arb_pick: a combinational two-requester picker (priority + starve, or round-robin) outputting the grant id.

Test Plan:
- IFU read alone, addr 0x8000_0010, sram_rdata_i = 0x1234_5678 -> sram_addr_o = 0x00004; ce_n low cycles 1-3; ifu_resp_o at cycle 4 with rdata 0x1234_5678; lsu_resp_o stays 0.
- IFU and LSU both request at cycle 0 -> LSU resp at cycle 4; IFU granted in IDLE at cycle 5, resp at cycle 9.
- LSU write, be_n = 4'b1100, wdata 0xCAFE_F00D -> we_n low only in cycle 2; oe_n = 1 throughout; be_n/addr/wdata stable for cycles 1-3.
- STARVE_LIMIT = 2, LSU issues back-to-back requests and IFU is held high -> LSU, LSU, then IFU granted on the third arbitration.
- rst asserted at the second ACCESS cycle -> next edge ce_n = 1, busy_o = 0, no resp on either port.
- SRAM_ARB_RR_EN defined, both requesters held high -> grants alternate LSU, IFU, LSU, IFU.
